// File: rtl/spiifc_mode.sv
// spiifc_mode: SPI slave that oversamples the SPI pins on SysClk and streams words between the master and the tx/rc RAMs.
// Build macro SPIIFC_LSB_FIRST_EN selects LSB-first word order on both MOSI and MISO; the default is MSB first.
module spiifc_mode #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  SysClk,
  input  logic                  Reset,
  input  logic [1:0]            Mode,
  input  logic                  SPI_CLK,
  input  logic                  SPI_MOSI,
  output logic                  SPI_MISO,
  input  logic                  SPI_SS,
  output logic [ADDR_WIDTH-1:0] txMemAddr,
  input  logic [DATA_WIDTH-1:0] txMemData,
  output logic [ADDR_WIDTH-1:0] rcMemAddr,
  output logic [DATA_WIDTH-1:0] rcMemData,
  output logic                  rcMemWE,
  output logic                  Busy,
  output logic                  FrameErr
);
  // state  | meaning
  // IDLE   | no frame; SPI_CLK edges ignored, MISO held at 0
  // ACTIVE | frame open; sampling MOSI, shifting MISO, streaming RAM words
  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [2:0]            clk_sync_q;
  logic [1:0]            mosi_sync_q;
  logic [2:0]            ss_sync_q;
  logic                  cpol_q, cpol_d, cpha_q, cpha_d;
  logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d, rc_data_q, rc_data_d;
  logic [DATA_WIDTH-2:0] rx_shift_q, rx_shift_d;
  logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [ADDR_WIDTH-1:0] tx_addr_q, tx_addr_d, rc_addr_q, rc_addr_d;
  logic                  we_q, we_d, ferr_q, ferr_d;
  logic                  load_req_q, load_req_d, load_now_q, load_now_d;
  logic                  lead_edge, trail_edge, sample_edge, shift_edge;
  logic                  ss_fall, ss_rise, mosi_s;
  logic [DATA_WIDTH-1:0] rx_full, tx_next;
  logic [DATA_WIDTH-2:0] rx_keep;
  logic                  tx_out;

  always_ff @(posedge SysClk or negedge Reset) begin
    if (!Reset) begin
      clk_sync_q  <= '0;
      mosi_sync_q <= '0;
      ss_sync_q   <= '1;
    end else begin
      clk_sync_q  <= {clk_sync_q[1:0], SPI_CLK};
      mosi_sync_q <= {mosi_sync_q[0], SPI_MOSI};
      ss_sync_q   <= {ss_sync_q[1:0], SPI_SS};
    end
  end

  assign mosi_s      = mosi_sync_q[1];
  assign ss_fall     = ss_sync_q[2] & ~ss_sync_q[1];
  assign ss_rise     = ~ss_sync_q[2] & ss_sync_q[1];
  assign lead_edge   = (clk_sync_q[1] != cpol_q) && (clk_sync_q[2] == cpol_q);
  assign trail_edge  = (clk_sync_q[1] == cpol_q) && (clk_sync_q[2] != cpol_q);
  assign sample_edge = cpha_q ? trail_edge : lead_edge;
  assign shift_edge  = cpha_q ? lead_edge : trail_edge;

`ifdef SPIIFC_LSB_FIRST_EN
  assign rx_full = {mosi_s, rx_shift_q};
  assign rx_keep = rx_full[DATA_WIDTH-1:1];
  assign tx_next = {1'b0, tx_shift_q[DATA_WIDTH-1:1]};
  assign tx_out  = tx_shift_q[0];
`else
  assign rx_full = {rx_shift_q, mosi_s};
  assign rx_keep = rx_full[DATA_WIDTH-2:0];
  assign tx_next = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
  assign tx_out  = tx_shift_q[DATA_WIDTH-1];
`endif

  always_comb begin
    state_d    = state_q;
    cpol_d     = cpol_q;
    cpha_d     = cpha_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    rc_data_d  = rc_data_q;
    bit_cnt_d  = bit_cnt_q;
    tx_addr_d  = tx_addr_q;
    rc_addr_d  = rc_addr_q;
    we_d       = 1'b0;
    ferr_d     = 1'b0;
    load_req_d = 1'b0;
    load_now_d = load_req_q;
    // RAM data is valid two cycles after the address moves: one to read, one to capture.
    if (load_now_q) tx_shift_d = txMemData;
    if (we_q) rc_addr_d = rc_addr_q + ADDR_WIDTH'(1);
    case (state_q)
      IDLE: begin
        if (ss_fall) begin
          cpol_d     = Mode[1];
          cpha_d     = Mode[0];
          tx_addr_d  = '0;
          rc_addr_d  = '0;
          bit_cnt_d  = '0;
          rx_shift_d = '0;
          load_req_d = 1'b1;
          state_d    = ACTIVE;
        end
      end
      ACTIVE: begin
        if (sample_edge) begin
          rx_shift_d = rx_keep;
          if (bit_cnt_q == CNT_LAST) begin
            rc_data_d  = rx_full;
            we_d       = 1'b1;
            bit_cnt_d  = '0;
            tx_addr_d  = tx_addr_q + ADDR_WIDTH'(1);
            load_req_d = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + CW'(1);
          end
        end
        // At a word boundary the freshly loaded word's first bit must stay exposed.
        if (shift_edge && (bit_cnt_q != '0)) tx_shift_d = tx_next;
        if (ss_rise) begin
          state_d = IDLE;
          ferr_d  = (bit_cnt_d != '0);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge SysClk or negedge Reset) begin
    if (!Reset) begin
      state_q    <= IDLE;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      rc_data_q  <= '0;
      bit_cnt_q  <= '0;
      tx_addr_q  <= '0;
      rc_addr_q  <= '0;
      we_q       <= 1'b0;
      ferr_q     <= 1'b0;
      load_req_q <= 1'b0;
      load_now_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cpol_q     <= cpol_d;
      cpha_q     <= cpha_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      rc_data_q  <= rc_data_d;
      bit_cnt_q  <= bit_cnt_d;
      tx_addr_q  <= tx_addr_d;
      rc_addr_q  <= rc_addr_d;
      we_q       <= we_d;
      ferr_q     <= ferr_d;
      load_req_q <= load_req_d;
      load_now_q <= load_now_d;
    end
  end

  assign txMemAddr = tx_addr_q;
  assign rcMemAddr = rc_addr_q;
  assign rcMemData = rc_data_q;
  assign rcMemWE   = we_q;
  assign FrameErr  = ferr_q;
  assign Busy      = (state_q == ACTIVE);
  assign SPI_MISO  = (state_q == ACTIVE) & tx_out;
endmodule

// File: tb/tb_spiifc_mode.sv
// tb_spiifc_mode: drives SPI frames in all four modes against a word-level model of the slave.
// Honours SPIIFC_LSB_FIRST_EN for the expected bit order.
module tb_spiifc_mode;
  localparam int H = 4;

  logic       SysClk = 1'b0;
  logic       Reset;
  logic [1:0] Mode;
  logic       SPI_CLK, SPI_MOSI, SPI_MISO, SPI_SS;
  logic [2:0] txMemAddr, rcMemAddr;
  logic [7:0] txMemData, rcMemData;
  logic       rcMemWE, Busy, FrameErr;

  logic [7:0] tx_ram [0:7];
  logic [7:0] rc_ram [0:7];
  logic [7:0] mw [0:15];
  logic       got_bits [0:255];
  logic [2:0] wr_a [$];
  logic [7:0] wr_d [$];
  int         ferr_cnt = 0;
  int         n_cmp = 0;
  int         n_bad = 0;

  spiifc_mode #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) dut (
    .SysClk(SysClk), .Reset(Reset), .Mode(Mode), .SPI_CLK(SPI_CLK), .SPI_MOSI(SPI_MOSI),
    .SPI_MISO(SPI_MISO), .SPI_SS(SPI_SS), .txMemAddr(txMemAddr), .txMemData(txMemData),
    .rcMemAddr(rcMemAddr), .rcMemData(rcMemData), .rcMemWE(rcMemWE), .Busy(Busy),
    .FrameErr(FrameErr)
  );

  always #5 SysClk = ~SysClk;

  always @(posedge SysClk) begin
    txMemData <= tx_ram[txMemAddr];
    if (rcMemWE) begin
      rc_ram[rcMemAddr] <= rcMemData;
      wr_a.push_back(rcMemAddr);
      wr_d.push_back(rcMemData);
    end
    if (FrameErr) ferr_cnt++;
  end

  function automatic logic bit_of(input logic [7:0] w, input int i);
`ifdef SPIIFC_LSB_FIRST_EN
    return w[i];
`else
    return w[7-i];
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < 8; i++) tx_ram[i] = 8'($urandom);
    for (int i = 0; i < 16; i++) mw[i] = 8'($urandom);
  endtask

  task automatic start_frame(input logic [1:0] md);
    Mode = md;
    SPI_CLK = md[1];
    repeat (4) @(negedge SysClk);
    SPI_SS = 1'b0;
    repeat (8) @(negedge SysClk);
  endtask

  task automatic xfer_bit(input logic [1:0] md, input logic b, input bit ss_up, output logic m);
    if (!md[0]) begin
      SPI_MOSI = b;
      repeat (H) @(negedge SysClk);
      m = SPI_MISO;
      SPI_CLK = ~md[1];
      if (ss_up) SPI_SS = 1'b1;
      repeat (H) @(negedge SysClk);
      SPI_CLK = md[1];
    end else begin
      SPI_CLK = ~md[1];
      SPI_MOSI = b;
      repeat (H) @(negedge SysClk);
      m = SPI_MISO;
      SPI_CLK = md[1];
      if (ss_up) SPI_SS = 1'b1;
      repeat (H) @(negedge SysClk);
    end
  endtask

  task automatic do_frame(input logic [1:0] md, input int nw, input int extra, input bit ss_last,
                          input string tag);
    int w0, f0, total, nb;
    logic m;
    logic [7:0] g, e;
    w0 = wr_a.size();
    f0 = ferr_cnt;
    total = nw * 8 + extra;
    start_frame(md);
    Mode = 2'($urandom);
    for (int i = 0; i < total; i++) begin
      xfer_bit(md, bit_of(mw[i/8], i % 8), ss_last && (i == total - 1), m);
      got_bits[i] = m;
    end
    if (!ss_last) begin
      repeat (H) @(negedge SysClk);
      SPI_SS = 1'b1;
    end
    repeat (8) @(negedge SysClk);
    check({tag, " write count"}, wr_a.size() - w0, nw);
    for (int k = 0; k < nw && (w0 + k) < wr_a.size(); k++) begin
      check($sformatf("%s waddr%0d", tag, k), {29'd0, wr_a[w0+k]}, k % 8);
      check($sformatf("%s wdata%0d", tag, k), {24'd0, wr_d[w0+k]}, {24'd0, mw[k]});
    end
    for (int k = 0; k <= nw; k++) begin
      nb = (k < nw) ? 8 : extra;
      if (nb > 0) begin
        g = '0;
        e = '0;
        for (int j = 0; j < nb; j++) begin
          g[j] = got_bits[k*8+j];
          e[j] = bit_of(tx_ram[k % 8], j);
        end
        check($sformatf("%s miso word%0d", tag, k), {24'd0, g}, {24'd0, e});
      end
    end
    check({tag, " frameerr pulses"}, ferr_cnt - f0, (extra != 0) ? 1 : 0);
    check({tag, " rc addr end"}, {29'd0, rcMemAddr}, nw % 8);
    check({tag, " tx addr end"}, {29'd0, txMemAddr}, nw % 8);
    check({tag, " busy/miso idle"}, {30'd0, Busy, SPI_MISO}, 0);
  endtask

  initial begin
    logic m;
    int w0;
    Reset = 1'b0;
    Mode = 2'd0;
    SPI_CLK = 1'b0;
    SPI_MOSI = 1'b0;
    SPI_SS = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tx_ram[i] = 8'd0;
      rc_ram[i] = 8'd0;
    end
    repeat (3) @(negedge SysClk);
    check("reset outputs", {14'd0, Busy, SPI_MISO, rcMemWE, FrameErr, txMemAddr, rcMemAddr, rcMemData}, 0);
    Reset = 1'b1;
    repeat (5) @(negedge SysClk);
    check("post-reset idle", {14'd0, Busy, SPI_MISO, rcMemWE, FrameErr, txMemAddr, rcMemAddr, rcMemData}, 0);

    // Reference frame in every mode: A5,3C in; 81,7E out.
    for (int md = 0; md < 4; md++) begin
      fill_random();
      tx_ram[0] = 8'h81;
      tx_ram[1] = 8'h7E;
      mw[0] = 8'hA5;
      mw[1] = 8'h3C;
      do_frame(2'(md), 2, 0, 1'b0, $sformatf("ref_m%0d", md));
      check($sformatf("ref_m%0d ram0", md), {24'd0, rc_ram[0]}, 32'hA5);
      check($sformatf("ref_m%0d ram1", md), {24'd0, rc_ram[1]}, 32'h3C);
    end

    for (int r = 0; r < 6; r++) begin
      fill_random();
      do_frame(2'($urandom_range(0, 3)), $urandom_range(1, 3), 0, 1'b0, $sformatf("rand%0d", r));
    end

    fill_random();
    do_frame(2'd0, 0, 5, 1'b0, "partial5");
    fill_random();
    do_frame(2'd3, 1, 3, 1'b0, "partial1w3");

    fill_random();
    do_frame(2'd2, 10, 0, 1'b0, "wrap");
    check("wrap ram0", {24'd0, rc_ram[0]}, {24'd0, mw[8]});
    check("wrap ram1", {24'd0, rc_ram[1]}, {24'd0, mw[9]});

    fill_random();
    do_frame(2'd1, 1, 0, 1'b1, "sim_m1");
    fill_random();
    do_frame(2'd0, 2, 0, 1'b1, "sim_m0");

    fill_random();
    w0 = wr_a.size();
    start_frame(2'd3);
    for (int i = 0; i < 19; i++) xfer_bit(2'd3, bit_of(mw[i/8], i % 8), 1'b0, m);
    Reset = 1'b0;
    #1;
    check("reset mid-frame outputs", {14'd0, Busy, SPI_MISO, rcMemWE, FrameErr, txMemAddr, rcMemAddr, rcMemData}, 0);
    check("reset mid-frame writes", wr_a.size() - w0, 2);
    SPI_SS = 1'b1;
    SPI_CLK = 1'b0;
    repeat (4) @(negedge SysClk);
    Reset = 1'b1;
    repeat (4) @(negedge SysClk);
    fill_random();
    do_frame(2'd0, 2, 0, 1'b0, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
